// File: rtl/rv_pkg.sv
// Shared RV decode definitions: opcodes, NOP, immediate formats
// and the decoded-field bundle used by the decode stage.
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic     uses_rs1;
        logic     uses_rs2;
        logic     writes_rd;
        imm_fmt_e fmt;
        logic     illegal;
    } dec_t;

    // Illegal instructions use no registers so they never stall.
    function automatic dec_t decode(input logic [31:0] instr,
                                    input int nregs);
        dec_t d;
        d = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0,
              fmt: FMT_NONE, illegal: 1'b0};
        unique case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d.writes_rd = 1'b1;
                d.fmt       = FMT_U;
            end
            OPC_JAL: begin
                d.writes_rd = 1'b1;
                d.fmt       = FMT_J;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                d.uses_rs1  = 1'b1;
                d.writes_rd = 1'b1;
                d.fmt       = FMT_I;
            end
            OPC_BRANCH: begin
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.fmt      = FMT_B;
            end
            OPC_STORE: begin
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.fmt      = FMT_S;
            end
            OPC_OP: begin
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = 1'b1;
                d.writes_rd = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        if ((d.uses_rs1 && int'(instr[19:15]) >= nregs) ||
            (d.uses_rs2 && int'(instr[24:20]) >= nregs) ||
            (d.writes_rd && int'(instr[11:7]) >= nregs))
            d.illegal = 1'b1;
        if (d.illegal)
            d = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0,
                  fmt: FMT_NONE, illegal: 1'b1};
        return d;
    endfunction

endpackage

// File: rtl/decode_sb_stage_if.sv
// Fetch, write-back and execute-side signals of the decode stage.
// The slave modport is the decode stage itself.
interface decode_sb_stage_if #(
    parameter int XLEN = 32
);
    localparam int SW = $clog2(XLEN);

    logic            if_valid_i;
    logic            if_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            flush_i;
    logic            wb_en_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            id_valid_o;
    logic            ex_ready_i;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] rs1_o;
    logic [XLEN-1:0] rs2_o;
    logic [XLEN-1:0] imm_o;
    logic [SW-1:0]   shamt_o;
    logic [4:0]      rd_o;
    logic            illegal_o;

    modport master (
        output if_valid_i, instr_i, pc_i, flush_i,
        output wb_en_i, wb_rd_i, wb_data_i, ex_ready_i,
        input  if_ready_o, id_valid_o, instr_o, pc_o,
        input  rs1_o, rs2_o, imm_o, shamt_o, rd_o, illegal_o
    );

    modport slave (
        input  if_valid_i, instr_i, pc_i, flush_i,
        input  wb_en_i, wb_rd_i, wb_data_i, ex_ready_i,
        output if_ready_o, id_valid_o, instr_o, pc_o,
        output rs1_o, rs2_o, imm_o, shamt_o, rd_o, illegal_o
    );

endinterface

// File: rtl/id_scoreboard.sv
// Per-register count of issued-but-not-written-back results,
// with RAW and saturation hazard detection for the buffered instruction.
module id_scoreboard #(
    parameter int NREGS = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_en,
    input  logic [4:0] issue_rd,
    input  logic       wb_en,
    input  logic [4:0] wb_rd,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       hazard
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0] cnt [32];

    for (genvar g = 0; g < 32; g++) begin : g_cnt
        if (g == 0 || g >= NREGS) begin : g_tie
            assign cnt[g] = '0;
        end else begin : g_reg
            logic          inc;
            logic          dec;
            logic [CW-1:0] q;
            assign inc = issue_en && issue_rd == 5'(g);
            assign dec = wb_en && wb_rd == 5'(g);
            // Same-cycle issue and write-back to one register cancel out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    q <= '0;
                else if (inc && !dec)
                    q <= q + 1'b1;
                else if (dec && !inc && q != '0)
                    q <= q - 1'b1;
            end
            assign cnt[g] = q;
        end
    end

    logic busy1;
    logic busy2;
    logic sat;

    // A lone pending write that lands this cycle is bypassed, not a hazard.
    always_comb begin
        busy1 = cnt[rs1] != '0 &&
                !(cnt[rs1] == CW'(1) && wb_en && wb_rd == rs1);
        busy2 = cnt[rs2] != '0 &&
                !(cnt[rs2] == CW'(1) && wb_en && wb_rd == rs2);
        sat = rd != '0 && cnt[rd] == CW'(MAX_INFLIGHT);
        hazard = (use_rs1 && rs1 != '0 && busy1) ||
                 (use_rs2 && rs2 != '0 && busy2) || sat;
    end

endmodule

// File: rtl/decode_sb_stage.sv
// RV decode stage: instruction buffer, regfile with write-back bypass,
// immediate generation and scoreboard-based issue.
module decode_sb_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input logic              clk_i,
    input logic              rstn_i,
    decode_sb_stage_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);

    logic            occ;
    logic [31:0]     ibuf;
    logic [XLEN-1:0] pbuf;
    logic [XLEN-1:0] rf [NREGS];

    dec_t       dec;
    logic       use1;
    logic       use2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       hazard;
    logic       id_valid;
    logic       issue;
    logic       if_ready;
    logic       accept;

    assign dec  = decode(ibuf, NREGS);
    assign rs1  = ibuf[19:15];
    assign rs2  = ibuf[24:20];
    assign use1 = occ && dec.uses_rs1;
    assign use2 = occ && dec.uses_rs2;
    assign rd   = (occ && dec.writes_rd) ? ibuf[11:7] : 5'd0;

    assign id_valid = occ && !hazard;
    assign issue    = id_valid && bus.ex_ready_i && !bus.flush_i;
    assign if_ready = !occ || issue;
    assign accept   = bus.if_valid_i && if_ready && !bus.flush_i;

    id_scoreboard #(
        .NREGS        (NREGS),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_sb (
        .clk      (clk_i),
        .rst_n    (rstn_i),
        .issue_en (issue),
        .issue_rd (rd),
        .wb_en    (bus.wb_en_i),
        .wb_rd    (bus.wb_rd_i),
        .use_rs1  (use1),
        .use_rs2  (use2),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .hazard   (hazard)
    );

    // Buffer refills on accept; flush kills both buffer and fetch.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            occ  <= 1'b0;
            ibuf <= NOP;
            pbuf <= '0;
        end else if (bus.flush_i) begin
            occ <= 1'b0;
        end else if (accept) begin
            occ  <= 1'b1;
            ibuf <= bus.instr_i;
            pbuf <= bus.pc_i;
        end else if (issue) begin
            occ <= 1'b0;
        end
    end

    // Register file write port; x0 and indices past NREGS are dropped.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (bus.wb_en_i && bus.wb_rd_i != 5'd0 &&
                     int'(bus.wb_rd_i) < NREGS) begin
            rf[bus.wb_rd_i[AW-1:0]] <= bus.wb_data_i;
        end
    end

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Operand read with same-cycle write-back forwarding.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (use1 && rs1 != 5'd0)
            rs1_val = (bus.wb_en_i && bus.wb_rd_i == rs1) ?
                      bus.wb_data_i : rf[rs1[AW-1:0]];
        if (use2 && rs2 != 5'd0)
            rs2_val = (bus.wb_en_i && bus.wb_rd_i == rs2) ?
                      bus.wb_data_i : rf[rs2[AW-1:0]];
    end

    logic [XLEN-1:0] imm;

    // Sign-extending immediate selection by format.
    always_comb begin
        imm = '0;
        if (occ) begin
            unique case (dec.fmt)
                FMT_I: imm = XLEN'($signed(ibuf[31:20]));
                FMT_S: imm = XLEN'($signed({ibuf[31:25], ibuf[11:7]}));
                FMT_B: imm = XLEN'($signed({ibuf[31], ibuf[7],
                             ibuf[30:25], ibuf[11:8], 1'b0}));
                FMT_U: imm = XLEN'($signed({ibuf[31:12], 12'b0}));
                FMT_J: imm = XLEN'($signed({ibuf[31], ibuf[19:12],
                             ibuf[20], ibuf[30:21], 1'b0}));
                default: imm = '0;
            endcase
        end
    end

    logic sh_en;

    // Only SLLI/SRLI/SRAI (funct3 x01) carry a shift amount.
    assign sh_en = occ && !dec.illegal &&
                   ibuf[6:0] == OPC_OP_IMM && ibuf[13:12] == 2'b01;

    assign bus.if_ready_o = if_ready;
    assign bus.id_valid_o = id_valid;
    assign bus.instr_o    = occ ? ibuf : NOP;
    assign bus.pc_o       = occ ? pbuf : '0;
    assign bus.rs1_o      = rs1_val;
    assign bus.rs2_o      = rs2_val;
    assign bus.imm_o      = imm;
    assign bus.shamt_o    = sh_en ? ibuf[20 +: SW] : '0;
    assign bus.rd_o       = rd;
    assign bus.illegal_o  = occ && dec.illegal;

endmodule
